// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the serial adder
package serial_add_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int SERIAL_ADD_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: job request and result bundle between requester and serial adder
interface serial_add_ctrl_if import serial_add_pkg::*; #(parameter int WIDTH = SERIAL_ADD_WIDTH);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/fullAdder.sv
// fullAdder: single-bit full adder slice
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one shared fullAdder slice, LSB first, one bit per clock
module serial_add_ctrl import serial_add_pkg::*; #(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input logic clk,
    input logic rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c;
    logic             last;
    fullAdder fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .Sum(s), .Cout(c));
    assign last = cnt == CNT_W'(WIDTH - 1);
    // sequencing: load on accepted start, shift one bit per RUN edge, pulse done after the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        bus.sum  <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    bus.sum <= {s, bus.sum[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= c;
                    cnt     <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        bus.cout <= c;
                        bus.ovf  <= carry ^ c;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for the serial adder at WIDTH=8 (directed) and WIDTH=4 (exhaustive)
module tb_serial_add_ctrl;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q8[$];
    exp_t q4[$];
    logic [7:0] held8;
    logic [3:0] held4;
    logic hv8 = 1'b0, hv4 = 1'b0, pd8 = 1'b0, pd4 = 1'b0;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // monitor for the 8-bit instance: result, latency, pulse width, hold
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hv8 = 1'b0;
        end else if (bus8.done) begin
            if (pd8) chk("pulse8", 1, 0);
            if (q8.size() == 0) chk("done8_unexpected", 1, 0);
            else begin
                e = q8.pop_front();
                chk("res8", {bus8.cout, bus8.ovf, bus8.sum}, {e.c, e.o, e.s});
                chk("lat8", cyc, e.at);
                held8 = e.s;
                hv8 = 1'b1;
            end
        end else if (!bus8.busy && hv8 && bus8.sum !== held8) begin
            chk("hold8", {24'd0, bus8.sum}, {24'd0, held8});
        end
        pd8 = bus8.done;
    end

    // monitor for the 4-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hv4 = 1'b0;
        end else if (bus4.done) begin
            if (pd4) chk("pulse4", 1, 0);
            if (q4.size() == 0) chk("done4_unexpected", 1, 0);
            else begin
                e = q4.pop_front();
                chk("res4", {bus4.cout, bus4.ovf, bus4.sum}, {e.c, e.o, e.s[3:0]});
                chk("lat4", cyc, e.at);
                held4 = e.s[3:0];
                hv4 = 1'b1;
            end
        end else if (!bus4.busy && hv4 && bus4.sum !== held4) begin
            chk("hold4", {28'd0, bus4.sum}, {28'd0, held4});
        end
        pd4 = bus4.done;
    end

    task automatic go8(logic [7:0] a, logic [7:0] b, logic cin, logic push,
                       logic [7:0] s, logic c, logic o);
        bus8.a = a;
        bus8.b = b;
        bus8.cin = cin;
        bus8.start = 1'b1;
        if (push) q8.push_back(exp_t'{s, c, o, cyc + 1 + 8});
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom);
    endtask

    task automatic go4(int a, int b, int cin);
        logic [3:0] x = 4'(a);
        logic [3:0] y = 4'(b);
        logic [4:0] r;
        r = {1'b0, x} + {1'b0, y} + 5'(cin);
        q4.push_back(exp_t'{{4'd0, r[3:0]}, r[4], (x[3] == y[3]) && (r[3] != x[3]), cyc + 1 + 4});
        bus4.a = x;
        bus4.b = y;
        bus4.cin = 1'(cin);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.a = 4'($urandom);
        bus4.b = 4'($urandom);
    endtask

    task automatic wait8();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus8.done) return;
        end
        chk("timeout8", 0, 1);
    endtask

    task automatic wait4();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus4.done) return;
        end
        chk("timeout4", 0, 1);
    endtask

    initial begin
        int nb;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset8", {bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum}, 0);
        chk("reset4", {bus4.busy, bus4.done, bus4.cout, bus4.ovf, bus4.sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // 0x7F + 0x01: signed overflow, busy for exactly 8 cycles
        go8(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        nb = 0;
        repeat (8) begin
            nb += int'(bus8.busy);
            @(negedge clk);
        end
        chk("busy_cnt", nb, 8);
        chk("busy_end", {bus8.busy, bus8.done}, 2'b01);
        repeat (2) @(negedge clk);
        // 0xA5 + 0x5A + 1, then back-to-back 0xFF + 0x01 issued in the DONE cycle
        go8(8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        wait8();
        go8(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        wait8();
        repeat (3) @(negedge clk);
        // start while busy is ignored
        go8(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        go8(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait8();
        repeat (12) @(negedge clk);
        // reset mid-RUN discards the job
        go8(8'h55, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_pre_rst", bus8.busy, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid", {bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go8(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        wait8();
        repeat (3) @(negedge clk);
        // exhaustive 4-bit sweep, mostly back-to-back with occasional idle gaps
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++) begin
                    go4(a, b, ci);
                    wait4();
                    if (b % 4 == 3 && ci == 1) repeat (2) @(negedge clk);
                end
        repeat (4) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q4_empty", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
